// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: command FIFO feeding one multicycle ALU,
// with a watchdog abort and a held response register.
module alu_cmd_queue #(
  parameter int N       = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [N-1:0]   cmd_a,
  input  logic [N-1:0]   cmd_b,
  input  logic [1:0]     cmd_op,
  output logic           alu_start,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [1:0]     alu_opcode,
  input  logic           alu_done,
  input  logic [2*N-1:0] alu_result,
  input  logic           alu_overflow,
  input  logic           alu_div_by_zero,
  input  logic           alu_zero,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*N-1:0] rsp_result,
  output logic [3:0]     rsp_flags,
  output logic [3:0]     rsp_tag
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nx;

  logic [N-1:0] mem_a   [DEPTH];
  logic [N-1:0] mem_b   [DEPTH];
  logic [1:0]   mem_op  [DEPTH];
  logic [3:0]   mem_tag [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    tag_cnt;
  logic [3:0]    hold_tag;
  logic [WW-1:0] wdog;

  logic full, empty, push, pop, fin_ok, fin_tmo;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == S_IDLE) && !empty;
  assign fin_ok    = (state == S_WAIT) && alu_done;
  assign fin_tmo   = (state == S_WAIT) && !alu_done
                     && (wdog == WD_LAST);

  // Queue storage; contents need no reset, pointers guard them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= cmd_a;
      mem_b[wr_ptr]   <= cmd_b;
      mem_op[wr_ptr]  <= cmd_op;
      mem_tag[wr_ptr] <= tag_cnt;
    end
  end

  // Pointers, occupancy and the sequence-tag counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        tag_cnt <= tag_cnt + 4'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (!empty) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (fin_ok || fin_tmo) state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Start pulse is simply the single ISSUE cycle.
  always_comb begin
    alu_start = (state == S_ISSUE);
  end

  // Operand hold registers change only on pop, so they stay
  // frozen for the whole ISSUE/WAIT span of a command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      hold_tag   <= '0;
    end else if (pop) begin
      alu_a      <= mem_a[rd_ptr];
      alu_b      <= mem_b[rd_ptr];
      alu_opcode <= mem_op[rd_ptr];
      hold_tag   <= mem_tag[rd_ptr];
    end
  end

  // Watchdog counts WAIT cycles without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
    end else if (state == S_ISSUE) begin
      wdog <= '0;
    end else if ((state == S_WAIT) && !alu_done) begin
      wdog <= wdog + WW'(1);
    end
  end

  // Response capture on done or abort; held until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_tag    <= '0;
    end else if (fin_ok) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_flags  <= {1'b0, alu_div_by_zero,
                     alu_overflow, alu_zero};
      rsp_tag    <= hold_tag;
    end else if (fin_tmo) begin
      rsp_valid  <= 1'b1;
      rsp_result <= '0;
      rsp_flags  <= 4'b1000;
      rsp_tag    <= hold_tag;
    end else if ((state == S_RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
